// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: state encoding and counter sizing helper.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET      = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_STABLE     = 3'd2,
    S_WAIT_CALIB = 3'd3,
    S_HOLD_WB    = 3'd4,
    S_HOLD_CPU   = 3'd5,
    S_RUN        = 3'd6
  } state_e;

  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, clears to 0 on async reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Ordered reset release for DDR2, Wishbone and CPU driven by clock locks,
// DDR2 calibration and a software re-cycle request.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES        = 16,
  parameter int unsigned CALIB_TIMEOUT      = 1048576,
  parameter int unsigned CNT_W = cnt_width(LOCK_STABLE_CYCLES, HOLD_CYCLES, CALIB_TIMEOUT)
) (
  input  logic       wb_clk_i,
  input  logic       rst_n_pad_i,
  input  logic       dcm_locked_i,
  input  logic       pll_locked_i,
  input  logic       ddr2_calib_done_i,
  input  logic       sw_rst_i,
  output logic       ddr2_rst_o,
  output logic       wb_rst_o,
  output logic       cpu_rst_o,
  output logic       calib_timeout_o,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] LS_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_TO    = CNT_W'(CALIB_TIMEOUT);

  logic dcm_s, pll_s, cal_s, lock_s;

  sync_2ff u_sync_dcm (.clk(wb_clk_i), .rst_n(rst_n_pad_i), .d(dcm_locked_i),      .q(dcm_s));
  sync_2ff u_sync_pll (.clk(wb_clk_i), .rst_n(rst_n_pad_i), .d(pll_locked_i),      .q(pll_s));
  sync_2ff u_sync_cal (.clk(wb_clk_i), .rst_n(rst_n_pad_i), .d(ddr2_calib_done_i), .q(cal_s));

  assign lock_s = dcm_s & pll_s;

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             cnt_clr;
  logic             timeout_d;

  always_comb begin
    state_d = state;
    cnt_clr = 1'b0;
    if (state != S_RESET && state != S_WAIT_LOCK && !lock_s) begin
      state_d = S_WAIT_LOCK;
    end else if ((state == S_HOLD_WB || state == S_HOLD_CPU || state == S_RUN) && sw_rst_i) begin
      // re-entering HOLD_WB from itself is not a state change, so clear explicitly
      state_d = S_HOLD_WB;
      cnt_clr = 1'b1;
    end else begin
      case (state)
        S_RESET:      state_d = S_WAIT_LOCK;
        S_WAIT_LOCK:  if (lock_s) state_d = S_STABLE;
        S_STABLE:     if (cnt == LS_LAST) state_d = S_WAIT_CALIB;
        S_WAIT_CALIB: if (cal_s) state_d = S_HOLD_WB;
        S_HOLD_WB:    if (cnt == HOLD_LAST) state_d = S_HOLD_CPU;
        S_HOLD_CPU:   if (cnt == HOLD_LAST) state_d = S_RUN;
        S_RUN:        state_d = S_RUN;
        default:      state_d = S_RESET;
      endcase
    end

    if (cnt_clr || state_d != state)
      cnt_d = '0;
    else if (state == S_WAIT_CALIB && cnt == CAL_TO)
      cnt_d = cnt;
    else
      cnt_d = cnt + CNT_W'(1);

    timeout_d = calib_timeout_o | (state_d == S_WAIT_CALIB && cnt_d == CAL_TO);
  end

  // Outputs decode the next state so they move on the same edge as state_o.
  always_ff @(posedge wb_clk_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      state           <= S_RESET;
      cnt             <= '0;
      ddr2_rst_o      <= 1'b1;
      wb_rst_o        <= 1'b1;
      cpu_rst_o       <= 1'b1;
      calib_timeout_o <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      ddr2_rst_o      <= (state_d == S_RESET) || (state_d == S_WAIT_LOCK) || (state_d == S_STABLE);
      wb_rst_o        <= !((state_d == S_HOLD_CPU) || (state_d == S_RUN));
      cpu_rst_o       <= (state_d != S_RUN);
      calib_timeout_o <= timeout_d;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench: each reset is modelled as an asserted interval [rise, fall)
// in edge numbers, derived from the documented release latencies.
module tb_rst_sequencer;

  localparam int LS    = 8;
  localparam int H     = 4;
  localparam int TO    = 32;
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       dcm = 1'b0, pll = 1'b0, cal = 1'b0, sw = 1'b0;
  logic       ddr2_rst, wb_rst, cpu_rst, calib_to;
  logic [2:0] st;

  int cyc = 0, n_chk = 0, n_pass = 0;
  int r_d, f_d, r_w, f_w, r_c, f_c, t_to;

  always #5 clk = ~clk;

  rst_sequencer #(
    .LOCK_STABLE_CYCLES(LS),
    .HOLD_CYCLES(H),
    .CALIB_TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk),
    .rst_n_pad_i(rst_n),
    .dcm_locked_i(dcm),
    .pll_locked_i(pll),
    .ddr2_calib_done_i(cal),
    .sw_rst_i(sw),
    .ddr2_rst_o(ddr2_rst),
    .wb_rst_o(wb_rst),
    .cpu_rst_o(cpu_rst),
    .calib_timeout_o(calib_to),
    .state_o(st)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d got %0h expected %0h", tag, cyc, obs, exp);
  endtask

  function automatic logic inwin(input int r, input int f);
    return (cyc >= r) && (cyc < f);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("ddr2_rst", ddr2_rst, inwin(r_d, f_d));
      chk("wb_rst",   wb_rst,   inwin(r_w, f_w));
      chk("cpu_rst",  cpu_rst,  inwin(r_c, f_c));
      chk("calib_to", calib_to, cyc >= t_to);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ddr2"},  ddr2_rst, 1'b1);
    chk({tag, "_wb"},    wb_rst,   1'b1);
    chk({tag, "_cpu"},   cpu_rst,  1'b1);
    chk({tag, "_to"},    calib_to, 1'b0);
    chk({tag, "_state"}, st,       3'd0);
  endtask

  initial begin
    int s, r, g, k, len, c;

    // Power-up with locks already high
    dcm = 1'b1;
    pll = 1'b1;
    #12;
    chk_reset_vals("por");

    // Nominal bring-up with a randomized calibration delay
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    r_d = 0; r_w = 0; r_c = 0; t_to = NEVER;
    f_d = 3 + LS;
    c   = f_d + $urandom_range(1, 12);
    f_w = c + 3 + H;
    f_c = c + 3 + 2 * H;
    step(1);
    chk("bringup_wait_lock", st, 3'd1);
    step(2);
    chk("bringup_stable", st, 3'd2);
    step(c - cyc);
    cal = 1'b1;
    step(f_c + 1 - cyc);
    chk("bringup_run", st, 3'd6);

    // Software reset pulse in RUN; DDR2 must stay released
    step($urandom_range(0, 4));
    s   = cyc;
    len = $urandom_range(1, 3);
    sw  = 1'b1;
    r_w = s + 1; r_c = s + 1;
    f_w = s + len + H;
    f_c = s + len + 2 * H;
    step(len);
    sw = 1'b0;
    chk("sw_hold_wb", st, 3'd4);
    step(f_c + 1 - cyc);
    chk("sw_run", st, 3'd6);

    // Lock loss in RUN, reacquire, then a short PLL glitch at STABLE count 5
    step($urandom_range(0, 5));
    s   = cyc;
    dcm = 1'b0;
    r_d = s + 3; r_w = s + 3; r_c = s + 3;
    f_d = NEVER; f_w = NEVER; f_c = NEVER;
    step(3);
    chk("lockloss_wait_lock", st, 3'd1);
    step($urandom_range(1, 4));
    r   = cyc;
    dcm = 1'b1;
    step(8);
    chk("glitch_stable", st, 3'd2);
    g   = cyc;
    k   = $urandom_range(1, 3);
    pll = 1'b0;
    f_d = g + k + 3 + LS;
    f_w = f_d + 1 + H;
    f_c = f_d + 1 + 2 * H;
    step(k);
    pll = 1'b1;
    step(g + 3 - cyc);
    chk("glitch_wait_lock", st, 3'd1);
    step(f_c + 1 - cyc);
    chk("glitch_run", st, 3'd6);

    // Calibration timeout: calib_done withdrawn, lock re-cycled, late calib_done
    step($urandom_range(0, 3));
    s   = cyc;
    dcm = 1'b0;
    cal = 1'b0;
    r_d = s + 3; r_w = s + 3; r_c = s + 3;
    f_d = NEVER; f_w = NEVER; f_c = NEVER;
    step(3 + $urandom_range(1, 4));
    r    = cyc;
    dcm  = 1'b1;
    f_d  = r + 3 + LS;
    t_to = f_d + TO;
    step(t_to + $urandom_range(1, 6) - cyc);
    chk("timeout_wait_calib", st, 3'd3);
    c   = cyc;
    cal = 1'b1;
    f_w = c + 3 + H;
    f_c = c + 3 + 2 * H;
    step(f_c + 1 - cyc);
    chk("timeout_run", st, 3'd6);

    // Async reset while in HOLD_CPU
    s   = cyc;
    sw  = 1'b1;
    r_w = s + 1; r_c = s + 1;
    f_w = s + 1 + H;
    f_c = s + 1 + 2 * H;
    step(1);
    sw = 1'b0;
    step(H + 1);
    chk("pre_async_hold_cpu", st, 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");

    // Release again: locks and calib already high, synchronizers restart from 0
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    r_d = 0; r_w = 0; r_c = 0; t_to = NEVER;
    f_d = 3 + LS;
    f_w = f_d + 1 + H;
    f_c = f_d + 1 + 2 * H;
    step(f_c + 1);
    chk("rerun_run", st, 3'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
